// File: rtl/seq_detect_moore_param_if.sv
// Serial detector bus: input stream, sampling controls and detect/count status.
interface seq_detect_moore_param_if #(
    parameter int unsigned CNT_W = 8
);
    logic             x;
    logic             en;
    logic             overlap;
    logic             clr;
    logic             y;
    logic [CNT_W-1:0] match_count;

    // Stream/control source side
    modport master (
        output x, en, overlap, clr,
        input  y, match_count
    );

    // Detector side
    modport slave (
        input  x, en, overlap, clr,
        output y, match_count
    );
endinterface

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial sequence detector with KMP next-state table,
// run-time overlap selection, sample enable and saturating match counter.
module seq_detect_moore_param #(
    parameter int unsigned          SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0]   PATTERN = 4'b1010,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_detect_moore_param_if.slave bus
);
    localparam int unsigned SW = $clog2(SEQ_LEN + 1);
    localparam int unsigned NS = SEQ_LEN + 1;

    // Sk (k = matched prefix length) uses binary value k; DETECT is k = SEQ_LEN.
    typedef enum logic [SW-1:0] {
        S0     = '0,
        DETECT = SW'(SEQ_LEN)
    } state_t;

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    // Pattern bit i (0 = first received) is PATTERN[SEQ_LEN-1-i].
    function automatic int unsigned kmp_next(input int unsigned k, input logic b);
        logic [15:0]  pat;
        logic         sbit;
        logic         ok;
        int unsigned  idx;
        int unsigned  maxl;
        pat  = 16'(PATTERN);
        maxl = (k + 1 > SEQ_LEN) ? SEQ_LEN : k + 1;
        for (int unsigned l = maxl; l >= 1; l--) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < l; i++) begin
                idx  = k + 1 - l + i;
                sbit = (idx == k) ? b : pat[4'(SEQ_LEN - 1 - idx)];
                if (pat[4'(SEQ_LEN - 1 - i)] != sbit) ok = 1'b0;
            end
            if (ok) return l;
        end
        return 0;
    endfunction

    // Flattened table: entry (2*k + b) holds the next state for state k, input b.
    function automatic logic [2*NS*SW-1:0] build_tbl();
        logic [2*NS*SW-1:0] t;
        t = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                t[(2*k + b)*SW +: SW] = SW'(kmp_next(k, 1'(b)));
            end
        end
        return t;
    endfunction

    localparam logic [2*NS*SW-1:0] NXT = build_tbl();

    state_t           r_state;
    logic             r_y;
    logic [CNT_W-1:0] r_count;
    logic [SW-1:0]    w_key;
    state_t           w_next;

    // Next-state lookup; non-overlap exit from DETECT reuses the S0 row,
    // and unused encodings match no row so they fall back to S0.
    always_comb begin
        w_key = r_state;
        if (r_state == DETECT && !bus.overlap) begin
            w_key = S0;
        end
        w_next = S0;
        for (int unsigned k = 0; k < NS; k++) begin
            if (w_key == SW'(k)) begin
                w_next = state_t'(NXT[(2*k + (bus.x ? 1 : 0))*SW +: SW]);
            end
        end
    end

    // State, registered detect output and saturating match counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S0;
            r_y     <= 1'b0;
            r_count <= '0;
        end else begin
            if (bus.en) begin
                r_state <= w_next;
                r_y     <= (w_next == DETECT);
            end
            if (bus.clr) begin
                r_count <= '0;
            end else if (bus.en && w_next == DETECT && r_count != '1) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign bus.y           = r_y;
    assign bus.match_count = r_count;
endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Directed bench for seq_detect_moore_param: default 1010 detector and a
// 3-bit all-ones detector with a 2-bit counter.
module tb_seq_detect_moore_param;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    seq_detect_moore_param_if #(.CNT_W(8)) bus_a ();
    seq_detect_moore_param_if #(.CNT_W(2)) bus_b ();

    seq_detect_moore_param #(.SEQ_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    seq_detect_moore_param #(.SEQ_LEN(3), .PATTERN(3'b111), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit into DUT A and sample 1 time unit after the edge.
    task automatic tick_a(input logic bx);
        bus_a.x = bx;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_b(input logic bx);
        bus_b.x = bx;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_a.en = 1'b1; bus_a.overlap = 1'b1; bus_a.clr = 1'b0; bus_a.x = 1'b0;
        bus_b.en = 1'b0; bus_b.overlap = 1'b1; bus_b.clr = 1'b0; bus_b.x = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (bus_a.y !== 1'b0) begin n_err++; $display("FAIL reset_y_a got=%b exp=0", bus_a.y); end
        n_cmp++; if (bus_a.match_count !== 8'd0) begin n_err++; $display("FAIL reset_cnt_a got=%0d exp=0", bus_a.match_count); end
        n_cmp++; if (bus_b.y !== 1'b0) begin n_err++; $display("FAIL reset_y_b got=%b exp=0", bus_b.y); end
        n_cmp++; if (bus_b.match_count !== 2'd0) begin n_err++; $display("FAIL reset_cnt_b got=%0d exp=0", bus_b.match_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_overlap();
        logic [10:0] xs;
        logic [10:0] ys;
        xs = 11'b10101011011;   // bit 1 is MSB
        ys = 11'b00010100000;   // y after bits 4 and 6
        do_reset();
        bus_a.overlap = 1'b1;
        for (int i = 10; i >= 0; i--) begin
            tick_a(xs[i]);
            n_cmp++;
            if (bus_a.y !== ys[i]) begin
                n_err++; $display("FAIL ovl_y bit=%0d got=%b exp=%b", 11 - i, bus_a.y, ys[i]);
            end
        end
        n_cmp++; if (bus_a.match_count !== 8'd2) begin n_err++; $display("FAIL ovl_cnt got=%0d exp=2", bus_a.match_count); end
    endtask

    task automatic test_nonoverlap();
        logic [10:0] xs;
        logic [10:0] ys;
        logic [3:0]  xs2;
        logic [3:0]  ys2;
        xs  = 11'b10101011011;
        ys  = 11'b00010000000;
        xs2 = 4'b1010;
        ys2 = 4'b0001;
        do_reset();
        bus_a.overlap = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            tick_a(xs[i]);
            n_cmp++;
            if (bus_a.y !== ys[i]) begin
                n_err++; $display("FAIL novl_y bit=%0d got=%b exp=%b", 11 - i, bus_a.y, ys[i]);
            end
        end
        n_cmp++; if (bus_a.match_count !== 8'd1) begin n_err++; $display("FAIL novl_cnt1 got=%0d exp=1", bus_a.match_count); end
        for (int i = 3; i >= 0; i--) begin
            tick_a(xs2[i]);
            n_cmp++;
            if (bus_a.y !== ys2[i]) begin
                n_err++; $display("FAIL novl2_y bit=%0d got=%b exp=%b", 4 - i, bus_a.y, ys2[i]);
            end
        end
        n_cmp++; if (bus_a.match_count !== 8'd2) begin n_err++; $display("FAIL novl_cnt2 got=%0d exp=2", bus_a.match_count); end
    endtask

    task automatic test_enable();
        do_reset();
        tick_a(1'b1); tick_a(1'b0); tick_a(1'b1);
        bus_a.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_a(i[0]);
            n_cmp++; if (bus_a.y !== 1'b0) begin n_err++; $display("FAIL en_hold_y cyc=%0d got=%b exp=0", i, bus_a.y); end
            n_cmp++; if (bus_a.match_count !== 8'd0) begin n_err++; $display("FAIL en_hold_cnt cyc=%0d got=%0d exp=0", i, bus_a.match_count); end
        end
        bus_a.en = 1'b1;
        tick_a(1'b0);
        n_cmp++; if (bus_a.y !== 1'b1) begin n_err++; $display("FAIL en_resume_y got=%b exp=1", bus_a.y); end
        n_cmp++; if (bus_a.match_count !== 8'd1) begin n_err++; $display("FAIL en_resume_cnt got=%0d exp=1", bus_a.match_count); end
        // clear with sampling disabled: count drops, DETECT and y held
        bus_a.en  = 1'b0;
        bus_a.clr = 1'b1;
        tick_a(1'b1);
        bus_a.clr = 1'b0;
        n_cmp++; if (bus_a.match_count !== 8'd0) begin n_err++; $display("FAIL clr_noen_cnt got=%0d exp=0", bus_a.match_count); end
        n_cmp++; if (bus_a.y !== 1'b1) begin n_err++; $display("FAIL clr_noen_y got=%b exp=1", bus_a.y); end
        bus_a.en = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [2:0] xs;
        do_reset();
        tick_a(1'b1); tick_a(1'b0); tick_a(1'b1); tick_a(1'b0);
        n_cmp++; if (bus_a.y !== 1'b1) begin n_err++; $display("FAIL arst_pre_y got=%b exp=1", bus_a.y); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus_a.y !== 1'b0) begin n_err++; $display("FAIL arst_y got=%b exp=0", bus_a.y); end
        n_cmp++; if (bus_a.match_count !== 8'd0) begin n_err++; $display("FAIL arst_cnt got=%0d exp=0", bus_a.match_count); end
        @(negedge clk);
        rst = 1'b0;
        // reach S3 then reset mid-cycle; the 101 prefix must be discarded
        tick_a(1'b1); tick_a(1'b0); tick_a(1'b1);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus_a.match_count !== 8'd0) begin n_err++; $display("FAIL arst_s3_cnt got=%0d exp=0", bus_a.match_count); end
        @(negedge clk);
        rst = 1'b0;
        xs = 3'b010;
        for (int i = 2; i >= 0; i--) begin
            tick_a(xs[i]);
            n_cmp++; if (bus_a.y !== 1'b0) begin n_err++; $display("FAIL arst_after_y bit=%0d got=%b exp=0", 3 - i, bus_a.y); end
        end
        n_cmp++; if (bus_a.match_count !== 8'd0) begin n_err++; $display("FAIL arst_after_cnt got=%0d exp=0", bus_a.match_count); end
    endtask

    task automatic test_saturate();
        logic [6:0] ys;
        logic [1:0] cs [7];
        ys = 7'b0011111;
        cs = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        bus_a.en = 1'b0;
        bus_b.en = 1'b1;
        bus_b.overlap = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick_b(1'b1);
            n_cmp++; if (bus_b.y !== ys[6 - i]) begin n_err++; $display("FAIL sat_y bit=%0d got=%b exp=%b", i + 1, bus_b.y, ys[6 - i]); end
            n_cmp++; if (bus_b.match_count !== cs[i]) begin n_err++; $display("FAIL sat_cnt bit=%0d got=%0d exp=%0d", i + 1, bus_b.match_count, cs[i]); end
        end
        bus_b.clr = 1'b1;
        tick_b(1'b1);
        bus_b.clr = 1'b0;
        n_cmp++; if (bus_b.match_count !== 2'd0) begin n_err++; $display("FAIL clr_prio_cnt got=%0d exp=0", bus_b.match_count); end
        n_cmp++; if (bus_b.y !== 1'b1) begin n_err++; $display("FAIL clr_prio_y got=%b exp=1", bus_b.y); end
        tick_b(1'b1);
        n_cmp++; if (bus_b.match_count !== 2'd1) begin n_err++; $display("FAIL post_clr_cnt got=%0d exp=1", bus_b.match_count); end
        bus_b.en = 1'b0;
        bus_a.en = 1'b1;
    endtask

    task automatic test_overlap_switch();
        do_reset();
        bus_a.overlap = 1'b1;
        tick_a(1'b1); tick_a(1'b0); tick_a(1'b1); tick_a(1'b0);
        n_cmp++; if (bus_a.y !== 1'b1) begin n_err++; $display("FAIL sw_det_y got=%b exp=1", bus_a.y); end
        bus_a.overlap = 1'b0;
        tick_a(1'b1);
        n_cmp++; if (bus_a.y !== 1'b0) begin n_err++; $display("FAIL sw_bit5_y got=%b exp=0", bus_a.y); end
        tick_a(1'b0);
        n_cmp++; if (bus_a.y !== 1'b0) begin n_err++; $display("FAIL sw_bit6_y got=%b exp=0", bus_a.y); end
        n_cmp++; if (bus_a.match_count !== 8'd1) begin n_err++; $display("FAIL sw_cnt got=%0d exp=1", bus_a.match_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus_a.x = 1'b0; bus_a.en = 1'b0; bus_a.overlap = 1'b1; bus_a.clr = 1'b0;
        bus_b.x = 1'b0; bus_b.en = 1'b0; bus_b.overlap = 1'b1; bus_b.clr = 1'b0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_enable();
        test_async_reset();
        test_saturate();
        test_overlap_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
